// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multiply / restoring divide
// that borrows the shared execute-stage ALU via req/gnt.
`ifndef ALU_FUNC_W
`define ALU_FUNC_W 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef FR_FLAG_W
`define FR_FLAG_W 4
`endif

module muldiv_seq #(
   parameter int DATA_W = 16,
   parameter int CF_BIT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   op,
   input  logic [DATA_W-1:0]      opa,
   input  logic [DATA_W-1:0]      opb,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_W-1:0]      res_hi,
   output logic [DATA_W-1:0]      res_lo,
   output logic                   div0,
   output logic                   alu_req,
   input  logic                   alu_gnt,
   output logic [DATA_W-1:0]      alu_a,
   output logic [DATA_W-1:0]      alu_b,
   output logic [`ALU_FUNC_W-1:0] alu_func,
   input  logic [DATA_W-1:0]      alu_y,
   input  logic [`FR_FLAG_W-1:0]  alu_flags
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE, S_REQ, S_RUN, S_DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic              is_div;
   logic [DATA_W-1:0] m;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic [DATA_W-1:0] hi_nx;
   logic [DATA_W-1:0] lo_nx;
   logic [DATA_W-1:0] s;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              zero_div;
   logic              step;
   logic              last;
   logic              c;
   logic              take;
   logic              unused_flags;

   assign accept   = (state == S_IDLE) && start;
   assign zero_div = op && (opb == '0);
   assign step     = (state == S_RUN) && alu_gnt;
   assign last     = (cnt == CNT_W'(DATA_W - 1));
   assign s        = {hi[DATA_W-2:0], lo[DATA_W-1]};
   assign c        = alu_flags[CF_BIT];
   assign take     = hi[DATA_W-1] | ~c;
   assign unused_flags = &{1'b0, alu_flags};

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (start) state_nx = zero_div ? S_DONE : S_REQ;
         S_REQ:  if (alu_gnt) state_nx = S_RUN;
         S_RUN:  if (step && last) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ALU drive and status outputs
   always_comb begin
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
      alu_req  = (state == S_REQ) || (state == S_RUN);
      alu_a    = '0;
      alu_b    = '0;
      alu_func = `ALU_ADD;
      if (state == S_RUN) begin
         if (is_div) begin
            alu_func = `ALU_SUB;
            alu_a    = s;
            alu_b    = m;
         end else begin
            alu_a = hi;
            alu_b = lo[0] ? m : '0;
         end
      end
   end

   // one shift-add / restoring-divide step from the ALU result
   always_comb begin
      hi_nx = hi;
      lo_nx = lo;
      if (is_div) begin
         hi_nx = take ? alu_y : s;
         lo_nx = {lo[DATA_W-2:0], take};
      end else begin
         hi_nx = {c, alu_y[DATA_W-1:1]};
         lo_nx = {alu_y[0], lo[DATA_W-1:1]};
      end
   end

   // operand latch, iteration registers and held results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         is_div <= 1'b0;
         m      <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         div0   <= 1'b0;
      end else if (accept) begin
         is_div <= op;
         m      <= op ? opb : opa;
         hi     <= '0;
         lo     <= op ? opa : opb;
         cnt    <= '0;
         div0   <= zero_div;
         if (zero_div) begin
            res_hi <= opa;
            res_lo <= '1;
         end
      end else if (step) begin
         hi  <= hi_nx;
         lo  <= lo_nx;
         cnt <= cnt + CNT_W'(1);
         if (last) begin
            res_hi <= hi_nx;
            res_lo <= lo_nx;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table vectors, grant-stall sequences, reset
// abort and random ops against an arithmetic reference.
`timescale 1ns/1ps
`ifndef ALU_FUNC_W
`define ALU_FUNC_W 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef FR_FLAG_W
`define FR_FLAG_W 4
`endif

module tb_muldiv_seq;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic                   op = 1'b0;
   logic [15:0]            opa = '0;
   logic [15:0]            opb = '0;
   logic                   alu_gnt = 1'b0;
   logic                   busy;
   logic                   done;
   logic [15:0]            res_hi;
   logic [15:0]            res_lo;
   logic                   div0;
   logic                   alu_req;
   logic [15:0]            alu_a;
   logic [15:0]            alu_b;
   logic [`ALU_FUNC_W-1:0] alu_func;
   logic [15:0]            alu_y;
   logic [`FR_FLAG_W-1:0]  alu_flags;

   int checks = 0;
   int failures = 0;

   muldiv_seq #(.DATA_W(16), .CF_BIT(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .opa(opa), .opb(opb), .busy(busy), .done(done),
      .res_hi(res_hi), .res_lo(res_lo), .div0(div0),
      .alu_req(alu_req), .alu_gnt(alu_gnt),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .alu_y(alu_y), .alu_flags(alu_flags)
   );

   always #5 clk = ~clk;

   // shared ALU stand-in: add with carry, subtract with borrow
   always_comb begin
      alu_y     = '0;
      alu_flags = '0;
      if (alu_func == `ALU_SUB) begin
         alu_y        = alu_a - alu_b;
         alu_flags[1] = (alu_a < alu_b);
      end else begin
         {alu_flags[1], alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic gnt_of(input int mode, input int k);
      if (mode == 1) return ($urandom_range(0, 3) != 0);
      if (mode == 2) return !(k <= 3 || k == 10 || k == 11);
      return 1'b1;
   endfunction

   task automatic ref_model(input logic o, input logic [15:0] a, b,
                            output logic [15:0] eh, el,
                            output logic ed0);
      logic [31:0] p;
      ed0 = 1'b0;
      if (!o) begin
         p  = 32'(a) * 32'(b);
         eh = p[31:16];
         el = p[15:0];
      end else if (b == 16'h0) begin
         eh  = a;
         el  = 16'hFFFF;
         ed0 = 1'b1;
      end else begin
         el = a / b;
         eh = a % b;
      end
   endtask

   // one operation: start in an IDLE cycle, grant per mode,
   // optionally pulse a stray start while busy and in DONE
   task automatic run_op(input logic o, input logic [15:0] a, b,
                         input int mode, input logic inject,
                         output logic [15:0] rh, rl,
                         output logic rd0, output int lat,
                         output int exp_lat, output logic req_seen);
      int  grants;
      logic got;
      logic g;
      rh = '0; rl = '0; rd0 = 1'b0;
      grants = 0; got = 1'b0; lat = 0; req_seen = 1'b0;
      exp_lat = (o && b == 16'h0) ? 1 : -1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      start = 1'b1; op = o; opa = a; opb = b; alu_gnt = 1'b1;
      for (int k = 1; k <= 300 && !got; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         op  = 1'($urandom);
         opa = 16'($urandom);
         opb = 16'($urandom);
         @(negedge clk);
         if (alu_req) req_seen = 1'b1;
         if (done) begin
            got = 1'b1;
            lat = k;
            rh  = res_hi;
            rl  = res_lo;
            rd0 = div0;
            chk("busy_at_done", 32'(busy), 32'd1);
            if (inject) start = 1'b1;
         end else begin
            chk("busy_while_run", 32'(busy), 32'd1);
            g = gnt_of(mode, k);
            if (g && exp_lat < 0) begin
               grants++;
               if (grants == 17) exp_lat = k + 1;
            end
            alu_gnt = g;
            if (inject && k == 5) begin
               start = 1'b1;
               op  = ~o;
               opa = ~a;
               opb = b + 16'd1;
            end
         end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
      if (inject) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
   endtask

   typedef struct {
      logic        op;
      logic [15:0] a;
      logic [15:0] b;
      int          mode;
      logic        inject;
      logic [15:0] ehi;
      logic [15:0] elo;
      logic        ed0;
      int          elat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [15:0] rh, rl, eh, el;
      logic        rd0, ed0, rq, o;
      logic [15:0] a, b;
      int          lat, elat, mode;

      vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0,
                  16'hFFFE, 16'h0001, 1'b0, 18};
      vecs[1] = '{1'b1, 16'h8000, 16'h0003, 0, 1'b0,
                  16'h0002, 16'h2AAA, 1'b0, 18};
      vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 0, 1'b0,
                  16'h0000, 16'h0001, 1'b0, 18};
      vecs[3] = '{1'b1, 16'h1234, 16'h0000, 0, 1'b0,
                  16'h1234, 16'hFFFF, 1'b1, 1};
      vecs[4] = '{1'b0, 16'h1234, 16'h0056, 2, 1'b0,
                  16'h0006, 16'h1D78, 1'b0, 23};
      vecs[5] = '{1'b0, 16'h00FF, 16'h0101, 0, 1'b1,
                  16'h0000, 16'hFFFF, 1'b0, 18};
      vecs[6] = '{1'b0, 16'h1234, 16'h0000, 0, 1'b0,
                  16'h0000, 16'h0000, 1'b0, 18};
      vecs[7] = '{1'b0, 16'h0002, 16'h0003, 0, 1'b0,
                  16'h0000, 16'h0006, 1'b0, 18};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_div0", 32'(div0), 32'd0);
      chk("rst_req", 32'(alu_req), 32'd0);
      chk("rst_res", {res_hi, res_lo}, 32'd0);
      chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
      chk("rst_func", 32'(alu_func), 32'(`ALU_ADD));
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].mode,
                vecs[i].inject, rh, rl, rd0, lat, elat, rq);
         chk($sformatf("vec%0d_hi", i), 32'(rh), 32'(vecs[i].ehi));
         chk($sformatf("vec%0d_lo", i), 32'(rl), 32'(vecs[i].elo));
         chk($sformatf("vec%0d_div0", i), 32'(rd0), 32'(vecs[i].ed0));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].elat));
         chk($sformatf("vec%0d_req", i), 32'(rq), 32'(!vecs[i].ed0));
      end

      // abort a multiply during its 8th iteration
      @(negedge clk);
      start = 1'b1; op = 1'b0; opa = 16'hAAAA; opb = 16'h5555;
      alu_gnt = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("abort_req_run", 32'(alu_req), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_req", 32'(alu_req), 32'd0);
      chk("abort_div0", 32'(div0), 32'd0);
      chk("abort_res", {res_hi, res_lo}, 32'd0);
      chk("abort_alu", {alu_a, alu_b}, 32'd0);
      chk("abort_func", 32'(alu_func), 32'(`ALU_ADD));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 40; i++) begin
         o = 1'($urandom);
         a = 16'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 16'h0 :
             ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15))
                                         : 16'($urandom);
         mode = int'($urandom_range(0, 1));
         ref_model(o, a, b, eh, el, ed0);
         run_op(o, a, b, mode, 1'b0, rh, rl, rd0, lat, elat, rq);
         chk($sformatf("rnd%0d_hi", i), 32'(rh), 32'(eh));
         chk($sformatf("rnd%0d_lo", i), 32'(rl), 32'(el));
         chk($sformatf("rnd%0d_div0", i), 32'(rd0), 32'(ed0));
         chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
